// File: rtl/router_port_if.sv
`default_nettype none
// ============================================================================
// Module   : router_port_if
// Purpose  : Node link and packet-side handshake bundle for router_port.
// Revision : 1.0 - initial release
// ============================================================================
interface router_port_if;
    // node link
    logic        free_to_node;
    logic        put_from_node;
    logic [7:0]  payload_from_node;
    logic        free_from_node;
    logic        put_to_node;
    logic [7:0]  payload_to_node;
    // packet side
    logic [31:0] pkt_out;
    logic        pkt_out_avail;
    logic        pkt_out_read;
    logic [31:0] pkt_in;
    logic        pkt_in_avail;
    logic        pkt_in_ready;

    modport slave (
        output free_to_node,
        input  put_from_node,
        input  payload_from_node,
        input  free_from_node,
        output put_to_node,
        output payload_to_node,
        output pkt_out,
        output pkt_out_avail,
        input  pkt_out_read,
        input  pkt_in,
        input  pkt_in_avail,
        output pkt_in_ready
    );

    modport master (
        input  free_to_node,
        output put_from_node,
        output payload_from_node,
        output free_from_node,
        input  put_to_node,
        input  payload_to_node,
        input  pkt_out,
        input  pkt_out_avail,
        output pkt_out_read,
        output pkt_in,
        output pkt_in_avail,
        input  pkt_in_ready
    );
endinterface
`default_nettype wire

// File: rtl/router_port.sv
`default_nettype none
// ============================================================================
// Module   : router_port
// Purpose  : Router port bridging a 4-beat byte link to show-ahead packet FIFOs.
// Revision : 1.0 - initial release
// ============================================================================

module router_port_fifo #(
    parameter int DEPTH = 2
) (
    input  wire logic        clock,
    input  wire logic        reset,
    input  wire logic        push,
    input  wire logic [31:0] wdata,
    input  wire logic        pop,
    output logic [31:0]      head,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            // simultaneous push and pop leaves the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module router_port #(
    parameter int DEPTH = 2
) (
    input  wire logic    clock,
    input  wire logic    reset,
    router_port_if.slave bus
);
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_B1   = 2'd1,
        RX_B2   = 2'd2,
        RX_B3   = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_B0   = 3'd1,
        TX_B1   = 3'd2,
        TX_B2   = 3'd3,
        TX_B3   = 3'd4
    } tx_state_t;

    // ---------------- receive path ----------------
    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic [7:0]  rx_byte0;
    logic [7:0]  rx_byte1;
    logic [7:0]  rx_byte2;
    logic        rx_push;
    logic [31:0] rx_pkt;
    logic [31:0] rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic        rx_accept;

    assign bus.free_to_node  = (rx_state == RX_IDLE) && !rx_full;
    assign rx_accept         = bus.free_to_node && bus.put_from_node;
    assign rx_push           = (rx_state == RX_B3);
    assign rx_pkt            = {rx_byte0, rx_byte1, rx_byte2, bus.payload_from_node};
    assign bus.pkt_out       = rx_head;
    assign bus.pkt_out_avail = !rx_empty;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (rx_accept) rx_next = RX_B1;
            RX_B1:   rx_next = RX_B2;
            RX_B2:   rx_next = RX_B3;
            RX_B3:   rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // byte captures need no reset: they are only consumed on the RX_B3 write
    always_ff @(posedge clock) begin
        if (rx_state == RX_IDLE && rx_accept) rx_byte0 <= bus.payload_from_node;
        if (rx_state == RX_B1)                rx_byte1 <= bus.payload_from_node;
        if (rx_state == RX_B2)                rx_byte2 <= bus.payload_from_node;
    end

    router_port_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_pkt),
        .pop   (bus.pkt_out_read),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // ---------------- transmit path ----------------
    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic        put_next;
    logic [7:0]  payload_next;
    logic        put_q;
    logic [7:0]  payload_q;
    logic [31:0] tx_head;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_pop;

    assign bus.pkt_in_ready    = !tx_full;
    assign bus.put_to_node     = put_q;
    assign bus.payload_to_node = payload_q;
    assign tx_pop              = (tx_state == TX_B3);

    // outputs are registered from the next state so beat k is on the wire in TX_Bk
    always_comb begin
        tx_next      = tx_state;
        payload_next = 8'h00;
        case (tx_state)
            TX_IDLE: if (!tx_empty && bus.free_from_node) tx_next = TX_B0;
            TX_B0:   tx_next = TX_B1;
            TX_B1:   tx_next = TX_B2;
            TX_B2:   tx_next = TX_B3;
            TX_B3:   tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
        case (tx_next)
            TX_B0:   payload_next = tx_head[31:24];
            TX_B1:   payload_next = tx_head[23:16];
            TX_B2:   payload_next = tx_head[15:8];
            TX_B3:   payload_next = tx_head[7:0];
            default: payload_next = 8'h00;
        endcase
        put_next = (tx_next != TX_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            put_q     <= 1'b0;
            payload_q <= 8'h00;
        end else begin
            tx_state  <= tx_next;
            put_q     <= put_next;
            payload_q <= payload_next;
        end
    end

    router_port_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.pkt_in_avail),
        .wdata (bus.pkt_in),
        .pop   (tx_pop),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );
endmodule
`default_nettype wire

// File: tb/tb_router_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_port
// Purpose  : Randomized scoreboard bench for router_port with directed preamble.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_router_port;
    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    router_port_if bus ();
    router_port #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // reference model: packet counts and link progress derived from the link rules
    bit          model_on = 1'b0;
    int          rx_beat  = 0;   // beats already taken of the inbound packet (0 = idle)
    int          rx_n     = 0;   // packets waiting in the receive FIFO
    int          tx_phase = 0;   // 0 idle, k = beat k-1 on the wire
    int          tx_n     = 0;   // packets waiting in the transmit FIFO
    logic [31:0] rx_q [$];
    logic [31:0] tx_q [$];
    bit          rx_acc, rd, tx_push, tx_start;

    initial forever begin
        @(posedge clock);
        if (model_on) begin
            rx_acc   = bus.put_from_node && rx_beat == 0 && rx_n < DEPTH;
            rd       = bus.pkt_out_read && rx_n > 0;
            tx_push  = bus.pkt_in_avail && tx_n < DEPTH;
            tx_start = tx_phase == 0 && tx_n > 0 && bus.free_from_node;
            if (rx_beat == 3) begin
                rx_beat = 0;
                rx_n++;
            end else if (rx_beat != 0 || rx_acc) begin
                rx_beat++;
            end
            if (rd) rx_n--;
            if (tx_phase == 4) begin
                tx_phase = 0;
                tx_n--;
            end else if (tx_phase != 0 || tx_start) begin
                tx_phase++;
            end
            if (tx_push) tx_n++;
        end
    end

    // monitor: compares flags every cycle and pops the scoreboards on output
    int          tx_mb = 0;
    logic [31:0] exp_pkt;
    initial forever begin
        @(negedge clock);
        if (model_on) begin
            check("free_to_node", bus.free_to_node, rx_beat == 0 && rx_n < DEPTH);
            check("pkt_out_avail", bus.pkt_out_avail, rx_n > 0);
            check("pkt_in_ready", bus.pkt_in_ready, tx_n < DEPTH);
            check("put_to_node", bus.put_to_node, tx_phase != 0);
            if (bus.pkt_out_read && bus.pkt_out_avail) begin
                if (rx_q.size() == 0) check("rx_unexpected", bus.pkt_out, 32'hxxxxxxxx);
                else check("pkt_out", bus.pkt_out, rx_q.pop_front());
            end
            if (bus.put_to_node) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", bus.payload_to_node, 32'hxxxxxxxx);
                end else begin
                    exp_pkt = tx_q[0];
                    check("tx_beat", bus.payload_to_node, exp_pkt[31-8*tx_mb -: 8]);
                    tx_mb++;
                    if (tx_mb == 4) begin
                        tx_mb = 0;
                        void'(tx_q.pop_front());
                    end
                end
            end else begin
                check("payload_idle", bus.payload_to_node, 8'h00);
            end
        end
    end

    // random stimulus; every bus input is driven from this one process
    bit          rx_run = 1'b0;
    bit          tx_run = 1'b0;
    int          free_pct, rd_pct;
    int          nd_idx = 0;
    logic [31:0] nd_pkt;

    task automatic drive_cycle();
        if (nd_idx != 0) begin
            if (nd_idx == 4) begin
                bus.put_from_node     = 1'b0;
                bus.payload_from_node = 8'h00;
                nd_idx = 0;
            end else begin
                bus.payload_from_node = nd_pkt[31-8*nd_idx -: 8];
                nd_idx++;
            end
        end else if (rx_run && rx_beat == 0 && rx_n < DEPTH && $urandom_range(0, 2) != 0) begin
            nd_pkt = $urandom;
            rx_q.push_back(nd_pkt);
            bus.put_from_node     = 1'b1;
            bus.payload_from_node = nd_pkt[31:24];
            nd_idx = 1;
        end else if (rx_run && rx_beat == 0 && rx_n == DEPTH && $urandom_range(0, 3) == 0) begin
            bus.put_from_node     = 1'b1;   // must be ignored while the port is full
            bus.payload_from_node = 8'($urandom);
        end else begin
            bus.put_from_node     = 1'b0;
            bus.payload_from_node = 8'h00;
        end
        bus.pkt_out_read   = ($urandom_range(0, 99) < rd_pct);
        bus.free_from_node = ($urandom_range(0, 99) < free_pct);
        bus.pkt_in         = $urandom;
        bus.pkt_in_avail   = tx_run && ($urandom_range(0, 1) == 1);
        if (bus.pkt_in_avail && tx_n < DEPTH) tx_q.push_back(bus.pkt_in);
    endtask

    initial begin
        logic [31:0] tx_pkt;
        reset                 = 1'b1;
        bus.put_from_node     = 1'b0;
        bus.payload_from_node = 8'h00;
        bus.free_from_node    = 1'b0;
        bus.pkt_out_read      = 1'b0;
        bus.pkt_in            = '0;
        bus.pkt_in_avail      = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_put", bus.put_to_node, 1'b0);
        check("rst_payload", bus.payload_to_node, 8'h00);
        check("rst_avail", bus.pkt_out_avail, 1'b0);
        check("rst_free", bus.free_to_node, 1'b1);
        check("rst_ready", bus.pkt_in_ready, 1'b1);

        // partial packet killed by reset while in RX_B2
        step(); bus.put_from_node = 1'b1; bus.payload_from_node = 8'hAA;
        step(); bus.payload_from_node = 8'hBB;
        step(); reset = 1'b1; bus.payload_from_node = 8'hCC;
        step(); reset = 1'b0; bus.put_from_node = 1'b0; bus.payload_from_node = 8'h00;
        @(negedge clock);
        check("midrst_avail", bus.pkt_out_avail, 1'b0);
        check("midrst_free", bus.free_to_node, 1'b1);
        step();
        @(negedge clock);
        check("midrst_avail2", bus.pkt_out_avail, 1'b0);

        // single inbound packet 12345678
        step(); bus.put_from_node = 1'b1; bus.payload_from_node = 8'h12;
        @(negedge clock); check("rx_free_b1", bus.free_to_node, 1'b1);
        step(); bus.payload_from_node = 8'h34;
        @(negedge clock); check("rx_free_b2", bus.free_to_node, 1'b0);
        step(); bus.payload_from_node = 8'h56;
        @(negedge clock); check("rx_free_b3", bus.free_to_node, 1'b0);
        step(); bus.payload_from_node = 8'h78;
        @(negedge clock); check("rx_free_b4", bus.free_to_node, 1'b0);
        check("rx_avail_b4", bus.pkt_out_avail, 1'b0);
        step(); bus.put_from_node = 1'b0; bus.payload_from_node = 8'h00; bus.pkt_out_read = 1'b1;
        @(negedge clock);
        check("rx_avail", bus.pkt_out_avail, 1'b1);
        check("rx_pkt", bus.pkt_out, 32'h12345678);
        step(); bus.pkt_out_read = 1'b0;
        @(negedge clock);
        check("rx_popped", bus.pkt_out_avail, 1'b0);
        check("rx_free_after", bus.free_to_node, 1'b1);

        // single outbound packet 05EAF00D
        tx_pkt = 32'h05EAF00D;
        step(); bus.pkt_in = tx_pkt; bus.pkt_in_avail = 1'b1; bus.free_from_node = 1'b1;
        @(negedge clock); check("tx_ready", bus.pkt_in_ready, 1'b1);
        step(); bus.pkt_in_avail = 1'b0;
        @(negedge clock); check("tx_put_n1", bus.put_to_node, 1'b0);
        for (int b = 0; b < 4; b++) begin
            step();
            @(negedge clock);
            check("tx_put_beat", bus.put_to_node, 1'b1);
            check("tx_beat_dir", bus.payload_to_node, tx_pkt[31-8*b -: 8]);
        end
        step();
        @(negedge clock);
        check("tx_put_end", bus.put_to_node, 1'b0);
        check("tx_payload_end", bus.payload_to_node, 8'h00);
        check("tx_ready_end", bus.pkt_in_ready, 1'b1);

        // randomized traffic: heavy backpressure first, then mostly flowing
        step();
        model_on = 1'b1;
        rx_run   = 1'b1;
        tx_run   = 1'b1;
        free_pct = 15;
        rd_pct   = 15;
        drive_cycle();
        for (int c = 0; c < 1500; c++) begin step(); drive_cycle(); end
        free_pct = 85;
        rd_pct   = 75;
        for (int c = 0; c < 1500; c++) begin step(); drive_cycle(); end
        rx_run   = 1'b0;
        tx_run   = 1'b0;
        free_pct = 100;
        rd_pct   = 100;
        for (int c = 0; c < 300; c++) begin
            step(); drive_cycle();
            if (rx_q.size() == 0 && tx_q.size() == 0 && nd_idx == 0
                && rx_beat == 0 && tx_phase == 0) break;
        end
        check("drain_rx", rx_q.size(), 0);
        check("drain_tx", tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
